// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with a one-word holding register.
// Frame format is set by DATA_W (5..9), PARITY (0 none, 1 odd, 2 even) and
// STOP_W (1 or 2). Define UART_RX_MAJ_EN to decide each bit by a 2-of-3
// majority vote around mid-bit instead of a single mid-bit sample.
module uart_rx_cfg #(
  parameter int CLK_F    = 50_000_000,
  parameter int UART_BPS = 115200,
  parameter int DATA_W   = 8,
  parameter int PARITY   = 0,
  parameter int STOP_W   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rxd,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              busy
);

  localparam int CLK_GOAL = CLK_F / UART_BPS;
  localparam int HALF     = CLK_GOAL / 2;
  localparam int CNT_W    = $clog2(CLK_GOAL + 1);
`ifdef UART_RX_MAJ_EN
  localparam int SAMP     = HALF + 1;
`else
  localparam int SAMP     = HALF;
`endif
  localparam logic [CNT_W-1:0] SAMP_C  = CNT_W'(SAMP);
  localparam logic [CNT_W-1:0] END_C   = CNT_W'(CLK_GOAL - 1);
  localparam logic [3:0]       LAST_D  = 4'(DATA_W - 1);
  localparam logic [3:0]       LAST_S  = 4'(STOP_W - 1);
  localparam logic             PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              rxd_p0, rxd_p1, rxd_p2;
  logic              fall, samp_now, cnt_end, bit_smp, par_exp;
  logic              par_pend, frm_pend;
  logic              vld_p0, vld_p1;

  // Line synchronizer plus one extra flop holding the previous synchronized sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= uart_rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  assign fall     = rxd_p2 & ~rxd_p1;
  assign samp_now = (cnt == SAMP_C);
  assign cnt_end  = (cnt == END_C);
  assign par_exp  = (^shreg) ^ PAR_ODD;

`ifdef UART_RX_MAJ_EN
  localparam logic [CNT_W-1:0] MAJ0_C = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] MAJ1_C = CNT_W'(HALF);

  logic maj_s0, maj_s1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Hold the two early samples; the third is the live sample at decision time
  always_ff @(posedge clk) begin
    if (cnt == MAJ0_C) maj_s0 <= rxd_p1;
    if (cnt == MAJ1_C) maj_s1 <= rxd_p1;
  end

  assign bit_smp = maj3(maj_s0, maj_s1, rxd_p1);
`else
  assign bit_smp = rxd_p1;
`endif

  // Next-state logic; vld_p0 marks the decision on the final stop bit
  always_comb begin
    state_d = state_q;
    vld_p0  = 1'b0;
    case (state_q)
      S_IDLE:   if (fall) state_d = S_START;
      S_START: begin
        if (samp_now && bit_smp) state_d = S_IDLE;
        else if (cnt_end)        state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_end && bit_idx == LAST_D)
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (cnt_end) state_d = S_STOP;
      S_STOP: begin
        if (samp_now && bit_idx == LAST_S) begin
          state_d = S_IDLE;
          vld_p0  = 1'b1;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // State register, bit-period counter, bit index and pending error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      par_pend <= 1'b0;
      frm_pend <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || state_q == S_IDLE || cnt_end) cnt <= '0;
      else                                                     cnt <= cnt + 1'b1;
      if (state_d != state_q) bit_idx <= '0;
      else if (cnt_end)       bit_idx <= bit_idx + 1'b1;
      if (state_q == S_IDLE && state_d == S_START) begin
        par_pend <= 1'b0;
        frm_pend <= 1'b0;
      end
      if (state_q == S_PARITY && samp_now && bit_smp != par_exp) par_pend <= 1'b1;
      if (state_q == S_STOP && samp_now && !bit_smp)             frm_pend <= 1'b1;
      vld_p1 <= vld_p0;
    end
  end

  // Data shift register, LSB arrives first so shift in from the top
  always_ff @(posedge clk) begin
    if (state_q == S_DATA && samp_now) shreg <= {bit_smp, shreg[DATA_W-1:1]};
  end

  // ---- stage boundary: completed frame -> holding register ----
  // Holding register with ready/valid handshake and overrun detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (vld_p1) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= par_pend;
          frame_err  <= frm_pend;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule
